// File: rtl/axis_video_frame_aligner.sv
// -----------------------------------------------------------------------------
// axis_video_frame_aligner
//
// Conditions a raw AXI4-Stream video source into frames of exactly
// WIDTH x HEIGHT pixels. Output tuser marks pixel (0,0) only, and output tlast
// marks x == WIDTH-1 only. Short lines are padded with PAD_VALUE, long lines
// are truncated, and beats arriving before a start-of-frame are dropped.
//
// Optional feature macro: AXIS_ALIGN_STATS_EN
//   When defined, adds frame_count (completed frames) and err_count
//   (saturating count of err_* pulses).
//
// Ports
//   clk, rst_n                 single clock, asynchronous active-low reset
//   s_axis_t{data,valid,last,user}, s_axis_tready   raw video input
//   m_axis_t{data,valid,last,user}, m_axis_tready   aligned video output
//                                                   (single output register)
//   err_sof_early   pulse: tuser accepted mid-frame
//   err_eol_early   pulse: tlast accepted before x == WIDTH-1
//   err_eol_late    pulse: x == WIDTH-1 accepted without tlast
//   frame_count, err_count   (AXIS_ALIGN_STATS_EN only)
// -----------------------------------------------------------------------------
module axis_video_frame_aligner #(
    parameter int unsigned            WIDTH       = 1920,
    parameter int unsigned            HEIGHT      = 1080,
    parameter int unsigned            DATA_WIDTH  = 24,
    parameter int unsigned            COORD_WIDTH = 16,
    parameter logic [DATA_WIDTH-1:0]  PAD_VALUE   = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  err_sof_early,
    output logic                  err_eol_early,
`ifdef AXIS_ALIGN_STATS_EN
    output logic                  err_eol_late,
    output logic [31:0]           frame_count,
    output logic [15:0]           err_count
`else
    output logic                  err_eol_late
`endif
);

    typedef enum logic [1:0] {
        ST_WAIT_SOF,
        ST_PASS,
        ST_PAD,
        ST_DISCARD
    } state_t;

    localparam logic [COORD_WIDTH-1:0] X_LAST = COORD_WIDTH'(WIDTH - 1);
    localparam logic [COORD_WIDTH-1:0] Y_LAST = COORD_WIDTH'(HEIGHT - 1);

    state_t                  state_q, state_d;
    logic [COORD_WIDTH-1:0]  x_q, x_d;
    logic [COORD_WIDTH-1:0]  y_q, y_d;
    logic [DATA_WIDTH-1:0]   m_tdata_q, m_tdata_d;
    logic                    m_tvalid_q, m_tvalid_d;
    logic                    m_tlast_q, m_tlast_d;
    logic                    m_tuser_q, m_tuser_d;
    logic                    err_sof_q, err_sof_d;
    logic                    err_early_q, err_early_d;
    logic                    err_late_q, err_late_d;

    logic                    load_en;
    logic                    s_tready_c;
    logic                    take;
    logic                    frame_done;
    logic [COORD_WIDTH-1:0]  xe;
    logic [COORD_WIDTH-1:0]  ye;

    assign load_en = !m_tvalid_q || m_axis_tready;

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        m_tuser_d   = m_tuser_q;
        err_sof_d   = 1'b0;
        err_early_d = 1'b0;
        err_late_d  = 1'b0;
        s_tready_c  = 1'b0;
        take        = 1'b0;
        frame_done  = 1'b0;
        xe          = x_q;
        ye          = y_q;

        // Register drains whenever it can load; a new beat below re-fills it.
        if (load_en) begin
            m_tvalid_d = 1'b0;
        end

        case (state_q)
            ST_WAIT_SOF: begin
                s_tready_c = load_en;
                if (s_axis_tvalid && load_en && s_axis_tuser) begin
                    take = 1'b1;
                    xe   = '0;
                    ye   = '0;
                end
            end
            ST_PASS: begin
                s_tready_c = load_en;
                if (s_axis_tvalid && load_en) begin
                    take = 1'b1;
                    if (s_axis_tuser && (x_q != '0 || y_q != '0)) begin
                        err_sof_d = 1'b1;
                        xe        = '0;
                        ye        = '0;
                    end
                end
            end
            ST_DISCARD: begin
                // Garbage is swallowed freely, but an SOF beat must be emitted,
                // so it is only accepted when the output register can take it.
                s_tready_c = !s_axis_tuser || load_en;
                if (s_axis_tvalid && s_axis_tuser && load_en) begin
                    take      = 1'b1;
                    err_sof_d = 1'b1;
                    xe        = '0;
                    ye        = '0;
                end else if (s_axis_tvalid && !s_axis_tuser && s_axis_tlast) begin
                    // y wraps to 0 only when the truncated line closed the frame
                    state_d = (y_q == '0) ? ST_WAIT_SOF : ST_PASS;
                end
            end
            ST_PAD: begin
                s_tready_c = 1'b0;
                if (load_en) begin
                    m_tvalid_d = 1'b1;
                    m_tdata_d  = PAD_VALUE;
                    m_tuser_d  = 1'b0;
                    m_tlast_d  = (x_q == X_LAST);
                    if (x_q == X_LAST) begin
                        x_d = '0;
                        if (y_q == Y_LAST) begin
                            y_d        = '0;
                            frame_done = 1'b1;
                            state_d    = ST_WAIT_SOF;
                        end else begin
                            y_d     = y_q + COORD_WIDTH'(1);
                            state_d = ST_PASS;
                        end
                    end else begin
                        x_d = x_q + COORD_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = ST_WAIT_SOF;
            end
        endcase

        // Common path for every input beat that is forwarded, at position (xe,ye).
        if (take) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = s_axis_tdata;
            m_tuser_d  = (xe == '0) && (ye == '0);
            m_tlast_d  = (xe == X_LAST);
            if (xe == X_LAST) begin
                x_d        = '0;
                err_late_d = !s_axis_tlast;
                if (ye == Y_LAST) begin
                    y_d        = '0;
                    frame_done = 1'b1;
                    state_d    = s_axis_tlast ? ST_WAIT_SOF : ST_DISCARD;
                end else begin
                    y_d     = ye + COORD_WIDTH'(1);
                    state_d = s_axis_tlast ? ST_PASS : ST_DISCARD;
                end
            end else begin
                x_d = xe + COORD_WIDTH'(1);
                y_d = ye;
                if (s_axis_tlast) begin
                    err_early_d = 1'b1;
                    state_d     = ST_PAD;
                end else begin
                    state_d = ST_PASS;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_WAIT_SOF;
            x_q         <= '0;
            y_q         <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            m_tuser_q   <= 1'b0;
            err_sof_q   <= 1'b0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            m_tuser_q   <= m_tuser_d;
            err_sof_q   <= err_sof_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
        end
    end

    // Held low in reset so every output reads 0 while rst_n is asserted.
    assign s_axis_tready = rst_n && s_tready_c;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tlast  = m_tlast_q;
    assign m_axis_tuser  = m_tuser_q;
    assign err_sof_early = err_sof_q;
    assign err_eol_early = err_early_q;
    assign err_eol_late  = err_late_q;

`ifdef AXIS_ALIGN_STATS_EN
    logic [31:0] frame_count_q, frame_count_d;
    logic [15:0] err_count_q, err_count_d;

    always_comb begin
        frame_count_d = frame_count_q;
        err_count_d   = err_count_q;
        if (frame_done) begin
            frame_count_d = frame_count_q + 32'd1;
        end
        if ((err_sof_d || err_early_d || err_late_d) && (err_count_q != 16'hFFFF)) begin
            err_count_d = err_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count_q <= '0;
            err_count_q   <= '0;
        end else begin
            frame_count_q <= frame_count_d;
            err_count_q   <= err_count_d;
        end
    end

    assign frame_count = frame_count_q;
    assign err_count   = err_count_q;
`else
    logic unused_frame_done;
    assign unused_frame_done = frame_done;
`endif

endmodule

// File: tb/tb_axis_video_frame_aligner.sv
// -----------------------------------------------------------------------------
// Bench for axis_video_frame_aligner (WIDTH=8, HEIGHT=4).
// A transaction-level model turns each accepted input beat into the list of
// output beats it must produce (padding is expanded in one go) and the error
// pulse it must raise; a per-cycle compare process checks the DUT against it.
// -----------------------------------------------------------------------------
module tb_axis_video_frame_aligner;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 24;
    localparam logic [DW-1:0] PADV = 24'hA5A5A5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tuser;
    logic          m_axis_tready = 1'b1;
    logic          err_sof_early;
    logic          err_eol_early;
    logic          err_eol_late;
`ifdef AXIS_ALIGN_STATS_EN
    logic [31:0]   frame_count;
    logic [15:0]   err_count;
`endif

    axis_video_frame_aligner #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .DATA_WIDTH (DW),
        .COORD_WIDTH(16),
        .PAD_VALUE  (PADV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .err_sof_early(err_sof_early),
        .err_eol_early(err_eol_early),
`ifdef AXIS_ALIGN_STATS_EN
        .err_eol_late (err_eol_late),
        .frame_count  (frame_count),
        .err_count    (err_count)
`else
        .err_eol_late (err_eol_late)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 'h%0h, expected 'h%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
        logic          u;
    } beat_t;

    beat_t         exp_q[$];
    logic [DW-1:0] obs_d[$];
    bit            obs_l[$];
    bit            obs_u[$];

    // mode: 0 = waiting for SOF, 1 = inside a frame, 2 = skipping rest of a long line
    int mx, my, mmode;
    bit pend_sof, pend_early, pend_late;

    task automatic m_push(input logic [DW-1:0] d);
        beat_t b;
        b.d = d;
        b.l = (mx == W - 1);
        b.u = (mx == 0) && (my == 0);
        exp_q.push_back(b);
    endtask

    task automatic m_next_line();
        mx = 0;
        my = (my + 1) % H;
    endtask

    task automatic model_beat(input logic [DW-1:0] d, input bit last, input bit user);
        if (!user && mmode == 0) return;
        if (!user && mmode == 2) begin
            if (last) mmode = (my == 0) ? 0 : 1;
            return;
        end
        if (user && (mmode == 2 || mx != 0 || my != 0)) pend_sof = 1;
        if (user) begin
            mx = 0;
            my = 0;
        end
        m_push(d);
        if (mx == W - 1) begin
            if (!last) pend_late = 1;
            m_next_line();
            mmode = !last ? 2 : ((my == 0) ? 0 : 1);
        end else if (last) begin
            pend_early = 1;
            mx++;
            while (mx < W) begin
                m_push(PADV);
                mx++;
            end
            mx = W - 1;
            m_next_line();
            mmode = (my == 0) ? 0 : 1;
        end else begin
            mx++;
            mmode = 1;
        end
    endtask

    // ---------------- per-cycle compare ----------------
    int n_acc = 0, n_out = 0, n_early = 0, n_late = 0, n_sof = 0, n_nrdy = 0;
    bit lat_chk = 0;
    bit prev_acc = 0, prev_v = 0, prev_r = 0;
    logic [26:0] prev_out = '0;

    always @(negedge clk) begin
        bit acc;
        beat_t e;
        #2;
        if (!rst_n) begin
            chk("reset_outputs",
                {s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tuser, m_axis_tdata,
                 err_sof_early, err_eol_early, err_eol_late}, 0);
            mx = 0; my = 0; mmode = 0;
            pend_sof = 0; pend_early = 0; pend_late = 0;
            exp_q.delete();
            prev_acc = 0; prev_v = 0; prev_r = 0;
        end else begin
            chk("err_pulses", {err_sof_early, err_eol_early, err_eol_late},
                {pend_sof, pend_early, pend_late});
            n_sof   += int'(err_sof_early);
            n_early += int'(err_eol_early);
            n_late  += int'(err_eol_late);
            if (prev_v && !prev_r)
                chk("stall_stable", {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser}, prev_out);
            if (lat_chk) chk("latency_1", m_axis_tvalid, prev_acc);
            if (m_axis_tvalid && m_axis_tready) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_beat", {m_axis_tdata, m_axis_tlast, m_axis_tuser}, e);
                end
                obs_d.push_back(m_axis_tdata);
                obs_l.push_back(m_axis_tlast);
                obs_u.push_back(m_axis_tuser);
                n_out++;
            end
            pend_sof = 0; pend_early = 0; pend_late = 0;
            acc = s_axis_tvalid && s_axis_tready;
            if (acc) begin
                n_acc++;
                model_beat(s_axis_tdata, s_axis_tlast, s_axis_tuser);
            end
            if (!s_axis_tready) n_nrdy++;
            prev_acc = acc;
            prev_v   = m_axis_tvalid;
            prev_r   = m_axis_tready;
            prev_out = {m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser};
        end
    end

    // ---------------- drivers ----------------
    int ready_pct = 100;
    int gap_pct   = 0;

    always @(negedge clk) m_axis_tready = ($urandom_range(99) < ready_pct);

    task automatic send(input logic [DW-1:0] d, input bit last, input bit user);
        int guard = 0;
        while ($urandom_range(99) < gap_pct) begin
            @(negedge clk);
            s_axis_tvalid = 1'b0;
        end
        @(negedge clk);
        s_axis_tvalid = 1'b1;
        s_axis_tdata  = d;
        s_axis_tlast  = last;
        s_axis_tuser  = user;
        #1;
        while (!s_axis_tready) begin
            guard++;
            if (guard > 1000) begin
                chk("send_timeout", 0, 1);
                s_axis_tvalid = 1'b0;
                return;
            end
            @(negedge clk);
            #1;
        end
    endtask

    task automatic send_line(input int n, input bit sof, input bit with_last);
        for (int i = 0; i < n; i++)
            send(DW'($urandom), with_last && (i == n - 1), sof && (i == 0));
    endtask

    task automatic clean_frame();
        for (int l = 0; l < H; l++) send_line(W, l == 0, 1);
    endtask

    task automatic drain();
        int i = 0;
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        do begin
            @(negedge clk);
            #3;
            i++;
        end while ((exp_q.size() != 0 || m_axis_tvalid) && i < 500);
        chk("drain_empty", exp_q.size(), 0);
        repeat (2) @(negedge clk);
    endtask

    int b_acc, b_out, b_early, b_late, b_sof, b_nrdy, b_obs;

    task automatic snap();
        b_acc = n_acc; b_out = n_out; b_early = n_early; b_late = n_late;
        b_sof = n_sof; b_nrdy = n_nrdy; b_obs = obs_d.size();
    endtask

    function automatic logic [31:0] last_vec();
        logic [31:0] v = '0;
        for (int k = 0; k < 32; k++) if (b_obs + k < obs_l.size()) v[k] = obs_l[b_obs + k];
        return v;
    endfunction

    function automatic logic [31:0] user_vec();
        logic [31:0] v = '0;
        for (int k = 0; k < 32; k++) if (b_obs + k < obs_u.size()) v[k] = obs_u[b_obs + k];
        return v;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // clean frame, back-to-back, downstream always ready
        lat_chk = 1;
        snap();
        clean_frame();
        drain();
        lat_chk = 0;
        chk("clean_out_count", n_out - b_out, 32);
        chk("clean_tlast_pos", last_vec(), 32'h80808080);
        chk("clean_tuser_pos", user_vec(), 32'h00000001);
        chk("clean_no_errs", (n_early - b_early) + (n_late - b_late) + (n_sof - b_sof), 0);

        // short line 1 (5 beats)
        snap();
        send_line(8, 1, 1); send_line(5, 0, 1); send_line(8, 0, 1); send_line(8, 0, 1);
        drain();
        chk("short_out_count", n_out - b_out, 32);
        chk("short_eol_early", n_early - b_early, 1);
        chk("short_tready_low", n_nrdy - b_nrdy, 3);
        chk("short_tlast_pos", last_vec(), 32'h80808080);
        for (int k = 13; k < 16; k++) chk("short_pad_data", obs_d[b_obs + k], PADV);

        // long line 2 (11 beats)
        snap();
        send_line(8, 1, 1); send_line(8, 0, 1); send_line(11, 0, 1); send_line(8, 0, 1);
        drain();
        chk("long_out_count", n_out - b_out, 32);
        chk("long_acc_count", n_acc - b_acc, 35);
        chk("long_eol_late", n_late - b_late, 1);
        chk("long_tlast_pos", last_vec(), 32'h80808080);

        // pre-SOF garbage
        snap();
        for (int i = 0; i < 10; i++) send(DW'($urandom), (i % 4) == 3, 0);
        clean_frame();
        drain();
        chk("garbage_acc_count", n_acc - b_acc, 42);
        chk("garbage_out_count", n_out - b_out, 32);
        chk("garbage_tuser_pos", user_vec(), 32'h00000001);
        chk("garbage_no_errs", (n_early - b_early) + (n_late - b_late) + (n_sof - b_sof), 0);

        // SOF at (3,2)
        snap();
        send_line(8, 1, 1); send_line(8, 0, 1); send_line(3, 0, 0);
        clean_frame();
        drain();
        chk("sof_out_count", n_out - b_out, 51);
        chk("sof_err_early", n_sof - b_sof, 1);
        chk("sof_restart_tuser", obs_u[b_obs + 19], 1);

        // random backpressure on a clean frame, then randomized malformed traffic
        ready_pct = 50;
        gap_pct   = 30;
        snap();
        clean_frame();
        drain();
        chk("bp_out_count", n_out - b_out, 32);
        for (int f = 0; f < 6; f++) begin
            int g = $urandom_range(3);
            for (int i = 0; i < g; i++) send(DW'($urandom), $urandom_range(1), 0);
            for (int l = 0; l < H; l++) begin
                int r = $urandom_range(9);
                int n = (r < 7) ? W : $urandom_range(1, 12);
                send_line(n, (l == 0) || (r == 9), 1);
            end
        end
        drain();

        // reset mid-line abandons the frame
        ready_pct = 100;
        gap_pct   = 0;
        send_line(3, 1, 0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        snap();
        clean_frame();
        drain();
        chk("post_reset_out_count", n_out - b_out, 32);
        chk("post_reset_tlast_pos", last_vec(), 32'h80808080);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
